psg_write_sequencer: RTL and testbench

- Shares the PSG command write port (addr 0x7F, MREQ_N/WR_N strobes, 8-bit data) between two requesters: req0 (CPU-side) and req1 (init/debug loader).
- Buffers bytes from each requester, arbitrates round-robin, and keeps two-byte tone commands (latch plus data) atomic.
- Generates bus cycles with enough idle spacing for the PSG command interface to latch and decode each byte.
- Sits between the requesters and the PSG comInterface inputs.

---
 rtl/psg_write_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_psg_write_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_write_sequencer.sv
// rtl/psg_write_sequencer.sv - two-requester PSG command write sequencer
//
// Purpose:
//   Shares the PSG command write port (address 0x007F, MREQ_N/WR_N strobes,
//   8-bit data) between two byte requesters. Each requester feeds its own
//   small FIFO. A round-robin arbiter picks the next byte. A tone latch byte
//   locks the arbiter to its source so that the following data byte goes out
//   immediately after it. Every byte is strobed for HOLD_CYCLES cycles. The
//   strobe is then followed by GAP_CYCLES idle cycles, so the PSG command
//   decoder can latch and decode it.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   req0_valid/data/ready    CPU-side byte push handshake
//   req1_valid/data/ready    init/debug loader byte push handshake
//   psg_addr                 0x007F while strobing, else 0x0000
//   psg_mreq_n, psg_wr_n     active-low strobes (registered)
//   psg_data                 byte being written, held through the gap
//   grant_id                 source of the current/last issued byte
//   busy                     sequencer active or any FIFO non-empty

module psg_write_sequencer_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push_valid,
  input  logic [7:0] i_push_data,
  output logic       o_push_ready,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;

  // Ready comes from the registered count only, so a full FIFO refuses a
  // byte even in the cycle its head is being popped.
  assign o_push_ready = (r_count != FULL_COUNT);
  assign o_empty      = (r_count == '0);
  assign o_head       = r_mem[r_rd_ptr];
  assign w_push       = i_push_valid && o_push_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module psg_write_sequencer #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 12,
  parameter int DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [15:0] psg_addr,
  output logic        psg_mreq_n,
  output logic        psg_wr_n,
  output logic [7:0]  psg_data,
  output logic        grant_id,
  output logic        busy
);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rr;        // requester favoured when both FIFOs hold data
  logic          r_lock;
  logic          r_lock_id;
  logic [15:0]   r_addr;
  logic          r_mreq_n;
  logic          r_wr_n;
  logic [7:0]    r_data;
  logic          r_grant;

  logic          w_empty0;
  logic          w_empty1;
  logic [7:0]    w_head0;
  logic [7:0]    w_head1;
  logic [7:0]    w_head;
  logic          w_elig;
  logic          w_sel;
  logic          w_start;
  logic          w_pop0;
  logic          w_pop1;
  logic          w_tone_latch;

  psg_write_sequencer_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (req0_valid),
    .i_push_data  (req0_data),
    .o_push_ready (req0_ready),
    .i_pop        (w_pop0),
    .o_head       (w_head0),
    .o_empty      (w_empty0)
  );

  psg_write_sequencer_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (req1_valid),
    .i_push_data  (req1_data),
    .o_push_ready (req1_ready),
    .i_pop        (w_pop1),
    .o_head       (w_head1),
    .o_empty      (w_empty1)
  );

  // While locked, only the locking requester may go next. The sequencer
  // waits for it and never falls back to the other requester.
  always_comb begin
    w_elig = 1'b0;
    w_sel  = 1'b0;
    if (r_lock) begin
      w_sel  = r_lock_id;
      w_elig = r_lock_id ? !w_empty1 : !w_empty0;
    end else if (!w_empty0 && !w_empty1) begin
      w_elig = 1'b1;
      w_sel  = r_rr;
    end else if (!w_empty0) begin
      w_elig = 1'b1;
      w_sel  = 1'b0;
    end else if (!w_empty1) begin
      w_elig = 1'b1;
      w_sel  = 1'b1;
    end
  end

  assign w_start = (r_state == S_IDLE) && w_elig;
  assign w_pop0  = w_start && !w_sel;
  assign w_pop1  = w_start && w_sel;
  assign w_head  = w_sel ? w_head1 : w_head0;

  // Tone frequency latch bytes (channels 0..2) need a data byte after them.
  // Volume and noise latches are complete on their own.
  assign w_tone_latch = w_head[7] &&
                        ((w_head[6:4] == 3'd0) || (w_head[6:4] == 3'd2) ||
                         (w_head[6:4] == 3'd4));

  assign busy = (r_state != S_IDLE) || !w_empty0 || !w_empty1;

  assign psg_addr   = r_addr;
  assign psg_mreq_n = r_mreq_n;
  assign psg_wr_n   = r_wr_n;
  assign psg_data   = r_data;
  assign grant_id   = r_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rr      <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
      r_addr    <= 16'h0000;
      r_mreq_n  <= 1'b1;
      r_wr_n    <= 1'b1;
      r_data    <= 8'h00;
      r_grant   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_DRIVE;
            r_cnt    <= HOLD_LOAD;
            r_mreq_n <= 1'b0;
            r_wr_n   <= 1'b0;
            r_addr   <= 16'h007F;
            r_data   <= w_head;
            r_grant  <= w_sel;
            if (r_lock) begin
              // Second byte of the pair is out; the pair is complete.
              r_lock <= 1'b0;
            end else begin
              r_rr <= ~w_sel;
              if (w_tone_latch) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
              end
            end
          end
        end
        S_DRIVE: begin
          if (r_cnt == '0) begin
            r_state  <= S_GAP;
            r_cnt    <= GAP_LOAD;
            r_mreq_n <= 1'b1;
            r_wr_n   <= 1'b1;
            r_addr   <= 16'h0000;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psg_write_sequencer.sv
// tb/tb_psg_write_sequencer.sv - directed self-checking bench for psg_write_sequencer
module tb_psg_write_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = 8'h00;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = 8'h00;
  logic        req1_ready;
  logic [15:0] psg_addr;
  logic        psg_mreq_n;
  logic        psg_wr_n;
  logic [7:0]  psg_data;
  logic        grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;

  logic [7:0] q_data[$];
  logic       q_gid[$];
  int         q_start[$];
  logic       prev_n = 1'b1;
  int         low_len = 0;

  psg_write_sequencer #(.HOLD_CYCLES(2), .GAP_CYCLES(12), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .psg_addr   (psg_addr),
    .psg_mreq_n (psg_mreq_n),
    .psg_wr_n   (psg_wr_n),
    .psg_data   (psg_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records each strobe start and tracks protocol violations.
  always @(negedge clk) begin
    if (reset) begin
      prev_n  = 1'b1;
      low_len = 0;
    end else begin
      if (psg_mreq_n !== psg_wr_n) viol++;
      if (psg_mreq_n === 1'b0) begin
        if (psg_addr !== 16'h007F) viol++;
        if (prev_n) begin
          q_data.push_back(psg_data);
          q_gid.push_back(grant_id);
          q_start.push_back(cyc);
          low_len = 1;
        end else begin
          low_len++;
        end
      end else begin
        if (psg_addr !== 16'h0000) viol++;
        if (!prev_n && low_len != 2) viol++;
      end
      prev_n = psg_mreq_n;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    q_data.delete();
    q_gid.delete();
    q_start.delete();
  endtask

  task automatic drain(output int done);
    done = -1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (!busy) begin
        done = cyc;
        break;
      end
    end
  endtask

  task automatic chk_entry(input string name, input int idx, input logic [7:0] d,
                           input logic g, input int st);
    logic [7:0] od = 8'hxx;
    logic       og = 1'bx;
    int         os = -1;
    if (idx < q_data.size()) begin
      od = q_data[idx];
      og = q_gid[idx];
      os = q_start[idx];
    end
    chk($sformatf("%s_data%0d", name, idx), 32'(od), 32'(d));
    chk($sformatf("%s_gid%0d", name, idx), 32'(og), 32'(g));
    chk($sformatf("%s_start%0d", name, idx), 32'(os), 32'(st));
  endtask

  initial begin
    int e0;
    int done;
    int rise;

    // Reset state
    do_reset();
    chk("rst_mreq_n", 32'(psg_mreq_n), 32'd1);
    chk("rst_wr_n", 32'(psg_wr_n), 32'd1);
    chk("rst_addr", 32'(psg_addr), 32'h0);
    chk("rst_data", 32'(psg_data), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd1);
    chk("rst_ready1", 32'(req1_ready), 32'd1);

    // Single byte
    req0_valid = 1'b1; req0_data = 8'h9F;
    tick(); e0 = cyc;
    req0_valid = 1'b0;
    drain(done);
    chk("single_busy_fall", 32'(done), 32'(e0 + 15));
    chk("single_count", 32'(q_data.size()), 32'd1);
    chk_entry("single", 0, 8'h9F, 1'b0, e0 + 1);
    chk("single_hold_data", 32'(psg_data), 32'h9F);

    // Round-robin
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h90;
    req1_valid = 1'b1; req1_data = 8'hD0;
    tick(); e0 = cyc;
    req0_data = 8'hB0; req1_data = 8'hF0;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(done);
    chk("rr_busy_fall", 32'(done), 32'(e0 + 60));
    chk("rr_count", 32'(q_data.size()), 32'd4);
    chk_entry("rr", 0, 8'h90, 1'b0, e0 + 1);
    chk_entry("rr", 1, 8'hD0, 1'b1, e0 + 16);
    chk_entry("rr", 2, 8'hB0, 1'b0, e0 + 31);
    chk_entry("rr", 3, 8'hF0, 1'b1, e0 + 46);

    // Atomic tone pair: req1 must wait behind the locked pair
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h85;
    req1_valid = 1'b1; req1_data = 8'h9F;
    tick(); e0 = cyc;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (19) tick();
    chk("atomic_wait_busy", 32'(busy), 32'd1);
    chk("atomic_wait_count", 32'(q_data.size()), 32'd1);
    req0_valid = 1'b1; req0_data = 8'h12;
    tick();
    req0_valid = 1'b0;
    drain(done);
    chk("atomic_busy_fall", 32'(done), 32'(e0 + 50));
    chk("atomic_count", 32'(q_data.size()), 32'd3);
    chk_entry("atomic", 0, 8'h85, 1'b0, e0 + 1);
    chk_entry("atomic", 1, 8'h12, 1'b0, e0 + 21);
    chk_entry("atomic", 2, 8'h9F, 1'b1, e0 + 36);

    // Attenuation latch does not lock
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h9A;
    req1_valid = 1'b1; req1_data = 8'hBF;
    tick(); e0 = cyc;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(done);
    chk("nolock_count", 32'(q_data.size()), 32'd2);
    chk_entry("nolock", 0, 8'h9A, 1'b0, e0 + 1);
    chk_entry("nolock", 1, 8'hBF, 1'b1, e0 + 16);

    // Full FIFO on req1 while a req0 byte occupies the bus
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h9F;
    tick(); e0 = cyc;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h01;
    tick();
    req1_data = 8'h02;
    tick();
    req1_data = 8'h03;
    tick();
    req1_data = 8'h04;
    tick();
    chk("full_ready1_low", 32'(req1_ready), 32'd0);
    chk("full_ready0_high", 32'(req0_ready), 32'd1);
    req1_data = 8'h05;
    rise = -1;
    for (int n = 0; n < 100; n++) begin
      if (req1_ready) begin
        rise = cyc;
        break;
      end
      tick();
    end
    chk("full_ready1_rise", 32'(rise), 32'(e0 + 16));
    tick();
    req1_valid = 1'b0;
    drain(done);
    chk("full_busy_fall", 32'(done), 32'(e0 + 90));
    chk("full_count", 32'(q_data.size()), 32'd6);
    chk_entry("full", 0, 8'h9F, 1'b0, e0 + 1);
    chk_entry("full", 1, 8'h01, 1'b1, e0 + 16);
    chk_entry("full", 2, 8'h02, 1'b1, e0 + 31);
    chk_entry("full", 3, 8'h03, 1'b1, e0 + 46);
    chk_entry("full", 4, 8'h04, 1'b1, e0 + 61);
    chk_entry("full", 5, 8'h05, 1'b1, e0 + 76);

    // Reset during the first strobe cycle
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h9F;
    req1_valid = 1'b1; req1_data = 8'h55;
    tick();
    req0_data = 8'hA0;
    req1_valid = 1'b0;
    tick();
    req0_valid = 1'b0;
    chk("midrst_strobe_low", 32'(psg_mreq_n), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_mreq_n", 32'(psg_mreq_n), 32'd1);
    chk("midrst_wr_n", 32'(psg_wr_n), 32'd1);
    chk("midrst_addr", 32'(psg_addr), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready0", 32'(req0_ready), 32'd1);
    chk("midrst_ready1", 32'(req1_ready), 32'd1);
    tick();
    reset = 1'b0;
    q_data.delete();
    q_gid.delete();
    q_start.delete();
    repeat (40) tick();
    chk("midrst_no_residual", 32'(q_data.size()), 32'd0);
    chk("midrst_idle_busy", 32'(busy), 32'd0);

    chk("bus_protocol", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
